// File: rtl/regfile_dump.sv
// regfile_dump: walks the integer register file and streams {index, data} beats.
// Define REGDUMP_CHECKSUM_EN to append a trailing XOR-checksum beat.
`ifndef REG_SIZE
`define REG_SIZE 32
`endif
`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif
`ifndef RS_WIDTH
`define RS_WIDTH 5
`endif

module regfile_dump #(
    parameter int NREGS = `REG_SIZE,
    parameter int DW    = `REG_DATA_WIDTH,
    parameter int AW    = `RS_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_index,
    output logic [DW-1:0] out_data,
    output logic          out_last
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_SEND = 3'd2;
    localparam logic [2:0] S_DONE = 3'd4;
`ifdef REGDUMP_CHECKSUM_EN
    localparam logic [2:0] S_CSUM = 3'd3;
`endif

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    logic [2:0]    state;
    logic [AW-1:0] idx;
    logic          fire;
`ifdef REGDUMP_CHECKSUM_EN
    logic [DW-1:0] csum;
`endif

    assign busy    = (state != S_IDLE);
    assign done    = (state == S_DONE);
    assign rd_addr = idx;
    assign fire    = out_valid && out_ready;
`ifdef REGDUMP_CHECKSUM_EN
    assign out_valid = (state == S_SEND) || (state == S_CSUM);
`else
    assign out_valid = (state == S_SEND);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            idx       <= '0;
            out_index <= '0;
            out_data  <= '0;
            out_last  <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        idx   <= '0;
                        state <= S_LOAD;
`ifdef REGDUMP_CHECKSUM_EN
                        csum  <= '0;
`endif
                    end
                end
                S_LOAD: begin
                    out_data  <= rd_data;
                    out_index <= idx;
                    state     <= S_SEND;
`ifdef REGDUMP_CHECKSUM_EN
                    csum      <= csum ^ rd_data;
                    out_last  <= 1'b0;
`else
                    out_last  <= (idx == LAST_IDX);
`endif
                end
                S_SEND: begin
                    if (fire) begin
                        if (idx == LAST_IDX) begin
`ifdef REGDUMP_CHECKSUM_EN
                            // Checksum beat reuses index 0 as its tag.
                            state     <= S_CSUM;
                            out_index <= '0;
                            out_data  <= csum;
                            out_last  <= 1'b1;
`else
                            state    <= S_DONE;
                            out_last <= 1'b0;
`endif
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= S_LOAD;
                        end
                    end
                end
`ifdef REGDUMP_CHECKSUM_EN
                S_CSUM: begin
                    if (fire) begin
                        state    <= S_DONE;
                        out_last <= 1'b0;
                    end
                end
`endif
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump: directed bench for regfile_dump with a beat-queue model.
// Follows REGDUMP_CHECKSUM_EN to expect the optional checksum beat.
module tb_regfile_dump;

    localparam int N = 32;
`ifdef REGDUMP_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif
    localparam int NB = N + CS;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        out_ready = 1'b0;
    logic        busy, done, out_valid, out_last;
    logic [4:0]  rd_addr, out_index;
    logic [31:0] rd_data, out_data;

    logic [31:0] rf [0:N-1];
    assign rd_data = rf[rd_addr];

    regfile_dump #(.NREGS(N), .DW(32), .AW(5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .busy(busy), .done(done), .rd_addr(rd_addr),
        .rd_data(rd_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_index(out_index),
        .out_data(out_data), .out_last(out_last)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t q[$];
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int t0 = 0;
    int base = 0;
    int beats = 0;
    int dones = 0;
    int stalls = 0;
    int done_cyc = 0;
    int acc_cyc [0:63];
    logic [31:0] acc_data [0:63];
    logic [4:0] acc_idx [0:63];
    logic hold = 1'b0;
    logic [37:0] hb = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compare process: every handshake against the expected beat queue.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                chk("stable_valid", 64'(out_valid), 64'd1);
                chk("stable_beat", 64'({out_index, out_data, out_last}),
                    64'(hb));
            end
            if (out_valid && out_ready) begin
                beat_t e;
                chk("beat_queued", 64'(q.size() != 0), 64'd1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("beat_index", 64'(out_index), 64'(e.idx));
                    chk("beat_data", 64'(out_data), 64'(e.data));
                    chk("beat_last", 64'(out_last), 64'(e.last));
                end
                if (beats - base < 64) begin
                    acc_cyc[beats - base] = cyc - t0;
                    acc_data[beats - base] = out_data;
                    acc_idx[beats - base] = out_index;
                end
                beats++;
            end
            if (out_valid && !out_ready) stalls++;
            if (done) begin
                chk("done_after_last", 64'(q.size()), 64'd0);
                dones++;
                done_cyc = cyc - t0;
            end
            hold = out_valid && !out_ready;
            hb = {out_index, out_data, out_last};
        end
    end

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic start_dump();
        logic [31:0] x;
        beat_t e;
        x = '0;
        q.delete();
        for (int i = 0; i < N; i++) begin
            e.idx = 5'(i);
            e.data = rf[i];
            e.last = (CS == 0) && (i == N - 1);
            q.push_back(e);
            x ^= rf[i];
        end
        if (CS != 0) begin
            e.idx = 5'd0;
            e.data = x;
            e.last = 1'b1;
            q.push_back(e);
        end
        base = beats;
        t0 = cyc;
        start = 1'b1;
        go();
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int d0;
        d0 = dones;
        for (int n = 0; n < limit && dones == d0; n++) begin
            @(negedge clk);
            #1;
        end
        chk("done_seen", 64'(dones - d0), 64'd1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_last"}, 64'(out_last), 64'd0);
        chk({tag, "_index"}, 64'(out_index), 64'd0);
        chk({tag, "_data"}, 64'(out_data), 64'd0);
        chk({tag, "_rd_addr"}, 64'(rd_addr), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, s0;
        logic wrote;
        for (int i = 0; i < N; i++)
            rf[i] = (i == 0) ? 32'h0 : 32'h1000_0000 + 32'(i);

        rst_n = 1'b0;
        go();
        go();
        chk_zero("reset");
        rst_n = 1'b1;
        go();

        // Full dump with the sink always ready.
        out_ready = 1'b1;
        start_dump();
        chk("load_busy", 64'(busy), 64'd1);
        chk("load_rd_addr", 64'(rd_addr), 64'd0);
        chk("load_valid", 64'(out_valid), 64'd0);
        wait_done(200);
        chk("t1_beats", 64'(beats - base), 64'(NB));
        chk("t1_first_cycle", 64'(acc_cyc[0]), 64'd2);
        chk("t1_first_data", 64'(acc_data[0]), 64'd0);
        chk("t1_last_reg_cycle", 64'(acc_cyc[31]), 64'd64);
        chk("t1_x31_data", 64'(acc_data[31]), 64'h1000_001F);
        chk("t1_done_cycle", 64'(done_cyc), 64'(65 + CS));
        if (CS != 0) begin
            chk("t1_csum_cycle", 64'(acc_cyc[32]), 64'd65);
            chk("t1_csum_index", 64'(acc_idx[32]), 64'd0);
            chk("t1_csum_data", 64'(acc_data[32]), 64'h1000_0000);
        end
        go();
        chk("t1_idle_after_done", 64'(busy), 64'd0);

        // Random ready, x5 rewritten while stalled on index 10.
        start_dump();
        s0 = stalls;
        d0 = dones;
        wrote = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            out_ready = 1'($urandom_range(0, 1));
            if (!wrote && out_valid && out_index == 5'd10) begin
                out_ready = 1'b0;
                rf[5] = 32'hDEAD_BEEF;
                wrote = 1'b1;
            end
            @(negedge clk);
            #1;
            if (dones != d0) break;
            go();
        end
        chk("t2_done_seen", 64'(dones - d0), 64'd1);
        chk("t2_x5_written", 64'(wrote), 64'd1);
        chk("t2_beats", 64'(beats - base), 64'(NB));
        chk("t2_x5_old", 64'(acc_data[5]), 64'h1000_0005);
        chk("t2_total_cycles", 64'(done_cyc), 64'(65 + CS + stalls - s0));
        out_ready = 1'b1;
        go();

        // Starts during a dump are ignored; start right after done works.
        start_dump();
        d0 = dones;
        for (int n = 0; n < 300; n++) begin
            start = (cyc - t0 == 5) || (cyc - t0 == 40);
            @(negedge clk);
            #1;
            if (dones != d0) break;
            go();
        end
        start = 1'b0;
        chk("t3_done_seen", 64'(dones - d0), 64'd1);
        chk("t3_beats", 64'(beats - base), 64'(NB));
        go();
        chk("t3_idle", 64'(busy), 64'd0);
        start_dump();
        wait_done(200);
        chk("t3_second_beats", 64'(beats - base), 64'(NB));
        repeat (5) go();
        chk("t3_done_count", 64'(dones - d0), 64'd2);
        chk("t3_quiet_busy", 64'(busy), 64'd0);

        // Asynchronous reset mid-dump.
        start_dump();
        for (int n = 0; n < 40 && cyc - t0 < 20; n++) go();
        chk("t4_pre_reset_valid", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("t4_async");
        q.delete();
        d0 = dones;
        go();
        go();
        rst_n = 1'b1;
        go();
        chk("t4_no_done", 64'(dones - d0), 64'd0);
        start_dump();
        wait_done(200);
        chk("t4_beats", 64'(beats - base), 64'(NB));
        chk("t4_first_index", 64'(acc_idx[0]), 64'd0);
        chk("t4_first_cycle", 64'(acc_cyc[0]), 64'd2);
        chk("t4_x5_new", 64'(acc_data[5]), 64'hDEAD_BEEF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
